// File: rtl/vencoder_pkg.sv
// Shared code definition for the convolutional encoder and its companion Viterbi decoder.
// Holds the default code and the parity helper used to form each coded bit.
package vencoder_pkg;

  localparam int              VENC_K    = 3;
  localparam logic [VENC_K-1:0] VENC_G0 = 3'b111;
  localparam logic [VENC_K-1:0] VENC_G1 = 3'b101;

  // Widest legal window; narrower windows are zero-extended before the parity call.
  localparam int VENC_KMAX = 9;

  typedef enum logic {
    PH_SAMPLE = 1'b0,
    PH_EMIT   = 1'b1
  } venc_phase_t;

  function automatic logic venc_parity(input logic [VENC_KMAX-1:0] vec,
                                       input logic [VENC_KMAX-1:0] mask);
    return ^(vec & mask);
  endfunction

endpackage

// File: rtl/venc_serializer.sv
// Two-phase serializer: emits c0 on the sampling edge, then the held c1 on the following edge.
// Exposes the phase so the encoder core knows when to shift its memory.
module venc_serializer
  import vencoder_pkg::*;
(
  input  logic Clock,
  input  logic reset,
  input  logic c0,
  input  logic c1,
  output logic sample,
  output logic out
);

  venc_phase_t phase, phase_next;
  logic        c1_hold;

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      phase   <= PH_SAMPLE;
      c1_hold <= 1'b0;
      out     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      phase <= phase_next;
      if (phase == PH_SAMPLE) begin
        out     <= c0;
        c1_hold <= c1;
      end else begin
        out     <= c1_hold;
      end
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves phase_next unassigned (no latch).
    phase_next = PH_SAMPLE;
    sample     = 1'b0;
    case (phase)
      PH_SAMPLE: begin
        phase_next = PH_EMIT;
        sample     = 1'b1;
      end
      PH_EMIT:   phase_next = PH_SAMPLE;
      default:   phase_next = PH_SAMPLE;
    endcase
  end

endmodule

// File: rtl/vencoder.sv
// Rate-1/2 feed-forward convolutional encoder, serial coded output (c0 then c1 per input bit).
// Encoder memory shifts only on sampling edges; the serializer handles output timing.
module vencoder
  import vencoder_pkg::*;
#(
  parameter int           K  = VENC_K,
  parameter logic [K-1:0] G0 = VENC_G0,
  parameter logic [K-1:0] G1 = VENC_G1
) (
  input  logic Clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic [K-2:0] sr;
  logic [K-1:0] w;
  logic         c0, c1;
  logic         sample;

  assign w  = {in, sr};
  assign c0 = venc_parity(VENC_KMAX'(w), VENC_KMAX'(G0));
  assign c1 = venc_parity(VENC_KMAX'(w), VENC_KMAX'(G1));

  // w[K-1:1] is {in, sr[K-2:1]}: newest bit enters at the MSB, oldest drops; also valid for K=2.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (sample) begin
      sr <= w[K-1:1];
    end
  end

  venc_serializer u_ser (
    .Clock  (Clock),
    .reset  (reset),
    .c0     (c0),
    .c1     (c1),
    .sample (sample),
    .out    (out)
  );

endmodule

// File: tb/tb_vencoder.sv
// Self-checking bench for vencoder: default K=3 code and a K=7 instance driven in lockstep.
// Reference model convolves the full input history with each generator.
module tb_vencoder;
  import vencoder_pkg::*;

  localparam int K7  = 7;
  localparam int G07 = 'b1111001;
  localparam int G17 = 'b1011011;

  logic Clock = 1'b0;
  logic reset;
  logic in;
  logic out3, out7;

  int vectors     = 0;
  int miscompares = 0;
  int unsigned hist[$];  // every bit sampled since the last reset, oldest first

  vencoder u_dut3 (
    .Clock (Clock),
    .reset (reset),
    .in    (in),
    .out   (out3)
  );

  vencoder #(.K(K7), .G0(7'b1111001), .G1(7'b1011011)) u_dut7 (
    .Clock (Clock),
    .reset (reset),
    .in    (in),
    .out   (out7)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %b expected %b", tag, $time, obs, exp);
    end
  endtask

  // Coded bit = XOR over taps j of g[k-1-j] * u[n-j]; bits before reset count as zero.
  function automatic logic code_bit(input int g, input int k);
    logic acc = 1'b0;
    for (int j = 0; j < k; j++) begin
      int unsigned b = (j < hist.size()) ? hist[hist.size()-1-j] : 0;
      if (((g >> (k-1-j)) & 1) != 0 && b != 0) acc = ~acc;
    end
    return acc;
  endfunction

  // Called between edges with the next rising edge being a sampling edge.
  task automatic send_bit(input logic b, input bit glitch, output logic o0, output logic o1);
    in = b;
    hist.push_back(int'(b));
    @(posedge Clock); #1;
    check("c0_k3", out3, code_bit(int'(VENC_G0), VENC_K));
    check("c0_k7", out7, code_bit(G07, K7));
    o0 = out3;
    if (glitch) in = ~b;
    @(posedge Clock); #1;
    check("c1_k3", out3, code_bit(int'(VENC_G1), VENC_K));
    check("c1_k7", out7, code_bit(G17, K7));
    o1 = out3;
    if (glitch) in = b;
  endtask

  initial begin
    logic o0, o1;
    logic kv_in [4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic kv_exp[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic imp_exp[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b0;
    in    = 1'b0;

    // Held in reset with input toggling: output stays 0 on every edge.
    repeat (6) begin
      @(posedge Clock); #1;
      in = 1'($urandom);
      check("rst_hold_k3", out3, 1'b0);
      check("rst_hold_k7", out7, 1'b0);
    end
    @(negedge Clock);
    reset = 1'b1;
    hist.delete();

    // Known vector, default code, from zero state.
    for (int i = 0; i < 4; i++) begin
      send_bit(kv_in[i], 1'b0, o0, o1);
      check("known_c0", o0, kv_exp[2*i]);
      check("known_c1", o1, kv_exp[2*i+1]);
    end

    // Asynchronous reset between edges while out is 1.
    #2 reset = 1'b0;
    #1;
    check("async_rst_k3", out3, 1'b0);
    check("async_rst_k7", out7, 1'b0);
    hist.delete();
    @(negedge Clock);
    reset = 1'b1;

    // All-zero input, then impulse response.
    repeat (10) send_bit(1'b0, 1'b0, o0, o1);
    for (int i = 0; i < 5; i++) begin
      send_bit((i == 0) ? 1'b1 : 1'b0, 1'b0, o0, o1);
      check("impulse_c0", o0, imp_exp[2*i]);
      check("impulse_c1", o1, imp_exp[2*i+1]);
    end

    // Input flipped across the phase-1 edge has no effect.
    send_bit(1'b1, 1'b1, o0, o1);
    check("glitch_c0", o0, 1'b1);
    check("glitch_c1", o1, 1'b1);
    repeat (6) send_bit(1'b0, 1'b0, o0, o1);

    // Reset mid-pair: c0 of a 1 emitted, reset before the c1 edge.
    in = 1'b1;
    hist.push_back(1);
    @(posedge Clock); #1;
    check("midpair_c0_k3", out3, code_bit(int'(VENC_G0), VENC_K));
    check("midpair_c0_k7", out7, code_bit(G07, K7));
    #2 reset = 1'b0;
    #1;
    check("midpair_rst_k3", out3, 1'b0);
    check("midpair_rst_k7", out7, 1'b0);
    hist.delete();
    @(posedge Clock); #1;
    check("midpair_held_k3", out3, 1'b0);
    @(negedge Clock);
    reset = 1'b1;
    send_bit(1'b0, 1'b0, o0, o1);
    check("midpair_fresh_c0", o0, 1'b0);
    check("midpair_fresh_c1", o1, 1'b0);

    // Random stream, both codes against the model.
    repeat (100) send_bit(1'($urandom), 1'b0, o0, o1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
